// File: rtl/rr_priority_encoder.sv
// Registered N-to-log2(N) priority encoder with fixed or round-robin arbitration.
// Each result is held behind a valid/ready handshake until the consumer accepts it.
module rr_priority_encoder #(
  parameter int N    = 8,
  parameter int MODE = 0,
  parameter int W    = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [N-1:0] d_in,
  input  logic         y_ready,
  output logic         y_valid,
  output logic [W-1:0] y_out,
  output logic         y_multi
);

  // Handshake: a result transfers on any rising edge where y_valid and y_ready
  // are both high. y_ready is ignored while y_valid is low. A new result may
  // load on the same edge the previous one is accepted, so there is no bubble.

  logic         y_valid_q, y_valid_d;
  logic [W-1:0] y_out_q, y_out_d;
  logic         y_multi_q, y_multi_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic         slot_free;
  logic         load;
  logic         found;
  logic [W-1:0] winner;
  logic         multi;
  int           j;

  assign slot_free = !y_valid_q || y_ready;
  assign load      = enable && (|d_in) && slot_free;
  // Clearing the lowest set bit leaves something only when two or more bits are set.
  assign multi     = |(d_in & (d_in - {{(N-1){1'b0}}, 1'b1}));

  always_comb begin
    winner = '0;
    found  = 1'b0;
    j      = 0;
    for (int i = 0; i < N; i++) begin
      if (MODE == 0) begin
        j = i;
      end else begin
        // Scan upward from ptr, wrapping straight from N-1 to 0.
        j = int'(ptr_q) + i;
        if (j >= N) j = j - N;
      end
      if (!found && d_in[j]) begin
        winner = W'(j);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    y_valid_d = y_valid_q;
    y_out_d   = y_out_q;
    y_multi_d = y_multi_q;
    ptr_d     = ptr_q;
    if (load) begin
      y_valid_d = 1'b1;
      y_out_d   = winner;
      y_multi_d = multi;
      if (MODE != 0) begin
        if (winner == W'(N - 1)) ptr_d = '0;
        else                     ptr_d = winner + W'(1);
      end
    end else if (y_valid_q && y_ready) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_valid_q <= 1'b0;
      y_out_q   <= '0;
      y_multi_q <= 1'b0;
      ptr_q     <= '0;
    end else begin
      y_valid_q <= y_valid_d;
      y_out_q   <= y_out_d;
      y_multi_q <= y_multi_d;
      ptr_q     <= ptr_d;
    end
  end

  assign y_valid = y_valid_q;
  assign y_out   = y_out_q;
  assign y_multi = y_multi_q;

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Directed bench: three encoders (fixed N=8, round-robin N=8, round-robin N=5)
// share clock and reset; each scenario task drives one of them and checks inline.
module tb_rr_priority_encoder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // fixed priority, N=8
  logic       f_en, f_ready, f_valid, f_multi;
  logic [7:0] f_d;
  logic [2:0] f_out;
  // round robin, N=8
  logic       r_en, r_ready, r_valid, r_multi;
  logic [7:0] r_d;
  logic [2:0] r_out;
  // round robin, N=5
  logic       p_en, p_ready, p_valid, p_multi;
  logic [4:0] p_d;
  logic [2:0] p_out;

  rr_priority_encoder #(.N(8), .MODE(0)) u_fix (
    .clk(clk), .rst(rst), .enable(f_en), .d_in(f_d), .y_ready(f_ready),
    .y_valid(f_valid), .y_out(f_out), .y_multi(f_multi)
  );

  rr_priority_encoder #(.N(8), .MODE(1)) u_rr (
    .clk(clk), .rst(rst), .enable(r_en), .d_in(r_d), .y_ready(r_ready),
    .y_valid(r_valid), .y_out(r_out), .y_multi(r_multi)
  );

  rr_priority_encoder #(.N(5), .MODE(1)) u_np (
    .clk(clk), .rst(rst), .enable(p_en), .d_in(p_d), .y_ready(p_ready),
    .y_valid(p_valid), .y_out(p_out), .y_multi(p_multi)
  );

  // Advance past the next rising edge; outputs are then stable for checking
  // and inputs written afterwards apply to the following edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    f_en = 1'b0; r_en = 1'b0; p_en = 1'b0;
    f_d  = '0;   r_d  = '0;   p_d  = '0;
    f_ready = 1'b1; r_ready = 1'b1; p_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    f_en = 1'b1; r_en = 1'b1; p_en = 1'b1;
    f_d = 8'hFF; r_d = 8'hFF; p_d = 5'h1F;
    f_ready = 1'b1; r_ready = 1'b1; p_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      tests_run++;
      if ({f_valid, f_out, f_multi} !== 5'b0_000_0) begin
        tests_failed++;
        $display("FAIL reset_fix cyc%0d: got v=%0b out=%0d m=%0b, want v=0 out=0 m=0", c, f_valid, f_out, f_multi);
      end
      tests_run++;
      if ({r_valid, r_out, r_multi, p_valid, p_out, p_multi} !== 10'b0) begin
        tests_failed++;
        $display("FAIL reset_rr cyc%0d: got rr v=%0b out=%0d m=%0b np v=%0b out=%0d m=%0b, want all 0",
                 c, r_valid, r_out, r_multi, p_valid, p_out, p_multi);
      end
    end
    rst = 1'b0;
    step();
    tests_run++;
    if ({f_valid, f_out, f_multi} !== 5'b1_000_1) begin
      tests_failed++;
      $display("FAIL reset_release_fix: got v=%0b out=%0d m=%0b, want v=1 out=0 m=1", f_valid, f_out, f_multi);
    end
    tests_run++;
    if ({r_valid, r_out, r_multi} !== 5'b1_000_1) begin
      tests_failed++;
      $display("FAIL reset_release_rr: got v=%0b out=%0d m=%0b, want v=1 out=0 m=1", r_valid, r_out, r_multi);
    end
  endtask

  task automatic test_fixed();
    do_reset();
    f_en = 1'b1; f_ready = 1'b1; f_d = 8'b0010_1000;
    for (int c = 0; c < 4; c++) begin
      step();
      tests_run++;
      if ({f_valid, f_out, f_multi} !== 5'b1_011_1) begin
        tests_failed++;
        $display("FAIL fixed_low cyc%0d: got v=%0b out=%0d m=%0b, want v=1 out=3 m=1", c, f_valid, f_out, f_multi);
      end
    end
    f_d = 8'b1000_0000;
    step();
    tests_run++;
    if ({f_valid, f_out, f_multi} !== 5'b1_111_0) begin
      tests_failed++;
      $display("FAIL fixed_top: got v=%0b out=%0d m=%0b, want v=1 out=7 m=0", f_valid, f_out, f_multi);
    end
  endtask

  task automatic test_rr_sweep();
    logic [2:0] exp_out;
    do_reset();
    r_en = 1'b1; r_ready = 1'b1; r_d = 8'hFF;
    for (int c = 0; c < 10; c++) begin
      step();
      exp_out = 3'(c % 8);
      tests_run++;
      if ({r_valid, r_out, r_multi} !== {1'b1, exp_out, 1'b1}) begin
        tests_failed++;
        $display("FAIL rr_sweep cyc%0d: got v=%0b out=%0d m=%0b, want v=1 out=%0d m=1", c, r_valid, r_out, r_multi, exp_out);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] toggles [4];
    toggles[0] = 8'hFF; toggles[1] = 8'h00; toggles[2] = 8'h01; toggles[3] = 8'hAA;
    do_reset();
    r_en = 1'b1; r_ready = 1'b1; r_d = 8'b0000_0100;
    step();
    tests_run++;
    if ({r_valid, r_out, r_multi} !== 5'b1_010_0) begin
      tests_failed++;
      $display("FAIL bp_load: got v=%0b out=%0d m=%0b, want v=1 out=2 m=0", r_valid, r_out, r_multi);
    end
    r_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      r_d = toggles[c];
      step();
      tests_run++;
      if ({r_valid, r_out, r_multi} !== 5'b1_010_0) begin
        tests_failed++;
        $display("FAIL bp_hold cyc%0d: got v=%0b out=%0d m=%0b, want v=1 out=2 m=0", c, r_valid, r_out, r_multi);
      end
    end
    // Pointer must still be 3, so the next grant from all-ones is 3, then 4.
    r_ready = 1'b1; r_d = 8'hFF;
    step();
    tests_run++;
    if ({r_valid, r_out, r_multi} !== 5'b1_011_1) begin
      tests_failed++;
      $display("FAIL bp_release: got v=%0b out=%0d m=%0b, want v=1 out=3 m=1", r_valid, r_out, r_multi);
    end
    step();
    tests_run++;
    if ({r_valid, r_out, r_multi} !== 5'b1_100_1) begin
      tests_failed++;
      $display("FAIL bp_next: got v=%0b out=%0d m=%0b, want v=1 out=4 m=1", r_valid, r_out, r_multi);
    end
  endtask

  task automatic test_enable_drain();
    do_reset();
    f_en = 1'b1; f_ready = 1'b1; f_d = 8'b0001_0000;
    step();
    tests_run++;
    if ({f_valid, f_out, f_multi} !== 5'b1_100_0) begin
      tests_failed++;
      $display("FAIL en_load: got v=%0b out=%0d m=%0b, want v=1 out=4 m=0", f_valid, f_out, f_multi);
    end
    f_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      tests_run++;
      if ({f_valid, f_out, f_multi} !== 5'b0_100_0) begin
        tests_failed++;
        $display("FAIL en_drain cyc%0d: got v=%0b out=%0d m=%0b, want v=0 out=4 m=0", c, f_valid, f_out, f_multi);
      end
    end
    // y_ready high while y_valid is low must not disturb anything; now hold a result.
    f_en = 1'b1; f_ready = 1'b0; f_d = 8'b0110_0000;
    step();
    step();
    tests_run++;
    if ({f_valid, f_out, f_multi} !== 5'b1_101_1) begin
      tests_failed++;
      $display("FAIL en_hold: got v=%0b out=%0d m=%0b, want v=1 out=5 m=1", f_valid, f_out, f_multi);
    end
    rst = 1'b1;
    step();
    rst = 1'b0; f_en = 1'b0;
    tests_run++;
    if ({f_valid, f_out, f_multi} !== 5'b0_000_0) begin
      tests_failed++;
      $display("FAIL en_midhold_rst: got v=%0b out=%0d m=%0b, want v=0 out=0 m=0", f_valid, f_out, f_multi);
    end
    step();
    tests_run++;
    if ({f_valid, f_out, f_multi} !== 5'b0_000_0) begin
      tests_failed++;
      $display("FAIL en_after_rst: got v=%0b out=%0d m=%0b, want v=0 out=0 m=0", f_valid, f_out, f_multi);
    end
  endtask

  task automatic test_npo2_wrap();
    logic [2:0] exp_a [4];
    logic [2:0] exp_b [6];
    exp_a[0] = 3'd0; exp_a[1] = 3'd4; exp_a[2] = 3'd0; exp_a[3] = 3'd4;
    for (int i = 0; i < 6; i++) exp_b[i] = 3'(i % 5);
    do_reset();
    p_en = 1'b1; p_ready = 1'b1; p_d = 5'b10001;
    for (int c = 0; c < 4; c++) begin
      step();
      tests_run++;
      if ({p_valid, p_out, p_multi} !== {1'b1, exp_a[c], 1'b1}) begin
        tests_failed++;
        $display("FAIL npo2_pair cyc%0d: got v=%0b out=%0d m=%0b, want v=1 out=%0d m=1", c, p_valid, p_out, p_multi, exp_a[c]);
      end
    end
    // Last grant was 4, so the pointer wrapped to 0: a full sweep restarts at 0.
    p_d = 5'h1F;
    for (int c = 0; c < 6; c++) begin
      step();
      tests_run++;
      if ({p_valid, p_out, p_multi} !== {1'b1, exp_b[c], 1'b1}) begin
        tests_failed++;
        $display("FAIL npo2_sweep cyc%0d: got v=%0b out=%0d m=%0b, want v=1 out=%0d m=1", c, p_valid, p_out, p_multi, exp_b[c]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    f_en = 1'b0; r_en = 1'b0; p_en = 1'b0;
    f_d = '0; r_d = '0; p_d = '0;
    f_ready = 1'b0; r_ready = 1'b0; p_ready = 1'b0;
    #2;
    test_reset();
    test_fixed();
    test_rr_sweep();
    test_backpressure();
    test_enable_drain();
    test_npo2_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
